// File: rtl/session_clock_if.sv
// session_clock_if: control/status bundle for the session wall clock.
// The master (seating controller) drives the load and alarm configuration.
// The slave (session_clock) returns the time, the tick and the alarm status.
interface session_clock_if #(
  parameter int N_CH = 4
) ();
  logic                load_en;
  logic [10:0]         load_time;
  logic                hold;
  logic [11*N_CH-1:0]  reset_time;
  logic [N_CH-1:0]     alarm_en;
  logic [N_CH-1:0]     alarm_clr;
  logic [10:0]         time_out;
  logic                min_tick;
  logic [N_CH-1:0]     rst_timer;
  logic [N_CH-1:0]     alarm_sts;
  logic                load_err;

  modport master (
    output load_en, load_time, hold, reset_time, alarm_en, alarm_clr,
    input  time_out, min_tick, rst_timer, alarm_sts, load_err
  );

  modport slave (
    input  load_en, load_time, hold, reset_time, alarm_en, alarm_clr,
    output time_out, min_tick, rst_timer, alarm_sts, load_err
  );
endinterface

// File: rtl/session_clock.sv
// session_clock: hour:minute wall clock with N_CH alarm channels.
// A prescaler divides clk into minute steps; loads take priority over steps.
// Alarms compare against the next-state time, and only on edges where the
// time is actually written, so editing an alarm onto the current time is silent.
// Optional feature macro: TIMER_HOLD_EN (hold input freezes counting).
module session_clock #(
  parameter int TICKS_PER_MIN = 2,
  parameter int N_CH          = 4,
  parameter int HOUR_MOD      = 24,
  parameter int MIN_MOD       = 60
) (
  input  logic            clk,
  input  logic            rst_n,
  session_clock_if.slave  bus
);

  localparam int              PW        = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [PW-1:0]   PRE_LAST  = PW'(TICKS_PER_MIN - 1);
  localparam logic [4:0]      HOUR_LAST = 5'(HOUR_MOD - 1);
  localparam logic [5:0]      MIN_LAST  = 6'(MIN_MOD - 1);
  localparam logic [5:0]      HOUR_LIM  = 6'(HOUR_MOD);
  localparam logic [6:0]      MIN_LIM   = 7'(MIN_MOD);

  logic [PW-1:0]   pre_q, pre_d;
  logic [10:0]     time_q, time_d;
  logic            min_tick_q, min_tick_d;
  logic [N_CH-1:0] rst_timer_q, rst_timer_d;
  logic [N_CH-1:0] alarm_sts_q, alarm_sts_d;
  logic            load_err_q, load_err_d;
  logic            time_wr;
  logic            hold_eff;

`ifdef TIMER_HOLD_EN
  assign hold_eff = bus.hold;
`else
  logic unused_hold;
  assign unused_hold = bus.hold;
  assign hold_eff    = 1'b0;
`endif

  function automatic logic in_range(input logic [10:0] t);
    return ({1'b0, t[10:6]} < HOUR_LIM) && ({1'b0, t[5:0]} < MIN_LIM);
  endfunction

  function automatic logic [10:0] next_minute(input logic [10:0] t);
    logic [4:0] hr;
    logic [5:0] mn;
    hr = t[10:6];
    mn = t[5:0];
    if (mn == MIN_LAST) begin
      mn = 6'd0;
      hr = (hr == HOUR_LAST) ? 5'd0 : hr + 5'd1;
    end else begin
      mn = mn + 6'd1;
    end
    return {hr, mn};
  endfunction

  // Next time and prescaler: valid load wins, bad load freezes, else count.
  always_comb begin
    pre_d      = pre_q;
    time_d     = time_q;
    min_tick_d = 1'b0;
    load_err_d = 1'b0;
    time_wr    = 1'b0;
    if (bus.load_en) begin
      if (in_range(bus.load_time)) begin
        time_d  = bus.load_time;
        pre_d   = '0;
        time_wr = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (!hold_eff) begin
      if (pre_q == PRE_LAST) begin
        pre_d      = '0;
        time_d     = next_minute(time_q);
        min_tick_d = 1'b1;
        time_wr    = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // Alarm hits against the time being written; time_d is always in range,
  // so an out-of-range alarm setting simply never matches.
  always_comb begin
    rst_timer_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      rst_timer_d[i] = time_wr && bus.alarm_en[i] &&
                       (time_d == bus.reset_time[11*i +: 11]);
    end
    alarm_sts_d = (alarm_sts_q & ~bus.alarm_clr) | rst_timer_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q       <= '0;
      time_q      <= '0;
      min_tick_q  <= 1'b0;
      rst_timer_q <= '0;
      alarm_sts_q <= '0;
      load_err_q  <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      time_q      <= time_d;
      min_tick_q  <= min_tick_d;
      rst_timer_q <= rst_timer_d;
      alarm_sts_q <= alarm_sts_d;
      load_err_q  <= load_err_d;
    end
  end

  assign bus.time_out  = time_q;
  assign bus.min_tick  = min_tick_q;
  assign bus.rst_timer = rst_timer_q;
  assign bus.alarm_sts = alarm_sts_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_session_clock.sv
// tb_session_clock: directed scenarios followed by random traffic, all
// checked every cycle against a minutes-since-midnight reference model.
module tb_session_clock;
  localparam int T    = 2;
  localparam int NCH  = 4;
  localparam int HM   = 24;
  localparam int MM   = 60;
  localparam int DAY  = HM * MM;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  session_clock_if #(.N_CH(NCH)) bus ();

  session_clock #(
    .TICKS_PER_MIN(T), .N_CH(NCH), .HOUR_MOD(HM), .MIN_MOD(MM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // reference model state
  int       m_tot;
  int       m_pre;
  bit       m_tick;
  bit       m_err;
  bit [3:0] m_hit;
  bit [3:0] m_sts;

  function automatic logic [10:0] mk(input int h, input int m);
    return {5'(h), 6'(m)};
  endfunction

  function automatic logic [10:0] exp_time();
    return mk(m_tot / MM, m_tot % MM);
  endfunction

  task automatic model_reset();
    m_tot = 0; m_pre = 0; m_tick = 0; m_err = 0; m_hit = '0; m_sts = '0;
  endtask

  task automatic model_edge();
    bit wr;
    bit hold_on;
    int h, m;
    logic [10:0] lt, rt;
    wr = 0; m_tick = 0; m_err = 0;
`ifdef TIMER_HOLD_EN
    hold_on = bus.hold;
`else
    hold_on = 0;
`endif
    if (bus.load_en) begin
      lt = bus.load_time;
      h = int'(lt[10:6]);
      m = int'(lt[5:0]);
      if (h < HM && m < MM) begin
        m_tot = h * MM + m; m_pre = 0; wr = 1;
      end else begin
        m_err = 1;
      end
    end else if (!hold_on) begin
      m_pre++;
      if (m_pre == T) begin
        m_pre = 0; m_tot = (m_tot + 1) % DAY; m_tick = 1; wr = 1;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      rt = bus.reset_time[11*i +: 11];
      h = int'(rt[10:6]);
      m = int'(rt[5:0]);
      m_hit[i] = wr && bus.alarm_en[i] && h < HM && m < MM && (h * MM + m == m_tot);
    end
    m_sts = (m_sts & ~bus.alarm_clr) | m_hit;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic compare();
    chk("time_out",  16'(bus.time_out),  16'(exp_time()));
    chk("min_tick",  16'(bus.min_tick),  16'(m_tick));
    chk("rst_timer", 16'(bus.rst_timer), 16'(m_hit));
    chk("alarm_sts", 16'(bus.alarm_sts), 16'(m_sts));
    chk("load_err",  16'(bus.load_err),  16'(m_err));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic load(input logic [10:0] v);
    bus.load_en = 1'b1;
    bus.load_time = v;
    step();
    bus.load_en = 1'b0;
  endtask

  // called one ns after a posedge: pulse reset well clear of the next edge
  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    compare();
    rst_n = 1'b1;
  endtask

  int          ticks;
  logic [10:0] saved;
  int          k;

  initial begin
    bus.load_en = 0; bus.load_time = '0; bus.hold = 0;
    bus.reset_time = '0; bus.alarm_en = '0; bus.alarm_clr = '0;
    model_reset();
    #2;
    compare();
    #5;
    rst_n = 1'b1;
    #3;

    // 1: free run from reset, 120 edges -> 01:00 and 60 ticks
    ticks = 0;
    repeat (120) begin
      step();
      ticks += int'(bus.min_tick);
    end
    chk("t1_time", 16'(bus.time_out), 16'(mk(1, 0)));
    chk("t1_ticks", 16'(ticks), 16'(60));

    // 2: day wrap
    load(mk(23, 59));
    chk("t2_load", 16'(bus.time_out), 16'(mk(23, 59)));
    chk("t2_tick_on_load", 16'(bus.min_tick), 16'(0));
    step(); step();
    chk("t2_wrap", 16'(bus.time_out), 16'(mk(0, 0)));
    chk("t2_tick", 16'(bus.min_tick), 16'(1));
    step();
    chk("t2_tick_one_cycle", 16'(bus.min_tick), 16'(0));

    // 3: multi-channel hit, sticky status, clear
    for (int i = 0; i < 3; i++) bus.reset_time[11*i +: 11] = mk(0, 5);
    bus.alarm_en = 4'b0101;
    load(mk(0, 0));
    repeat (10) step();
    chk("t3_time", 16'(bus.time_out), 16'(mk(0, 5)));
    chk("t3_hit", 16'(bus.rst_timer), 16'(4'b0101));
    chk("t3_sts", 16'(bus.alarm_sts), 16'(4'b0101));
    step();
    chk("t3_hit_once", 16'(bus.rst_timer), 16'(0));
    bus.alarm_clr = 4'b0001;
    step();
    bus.alarm_clr = 4'b0000;
    chk("t3_clr", 16'(bus.alarm_sts), 16'(4'b0100));

    // 4: out-of-range loads
    saved = exp_time();
    load(mk(24, 0));
    chk("t4_err_hour", 16'(bus.load_err), 16'(1));
    chk("t4_time_kept", 16'(bus.time_out), 16'(saved));
    step();
    chk("t4_err_pulse", 16'(bus.load_err), 16'(0));
    load(mk(3, 60));
    chk("t4_err_min", 16'(bus.load_err), 16'(1));

    // 5: editing an alarm onto the current time is silent; reloading fires
    load(mk(0, 7));
    bus.reset_time[33 +: 11] = mk(0, 7);
    bus.alarm_en[3] = 1'b1;
    step();
    chk("t5_edit_silent", 16'(bus.rst_timer), 16'(0));
    load(mk(0, 7));
    chk("t5_reload_hit", 16'(bus.rst_timer), 16'(4'b1000));

    // mid-count reset discards prescaler progress
    load(mk(5, 5));
    step();
    do_reset();
    step();
    chk("rst_no_early_tick", 16'(bus.min_tick), 16'(0));
    step();
    chk("rst_tick", 16'(bus.min_tick), 16'(1));
    chk("rst_time", 16'(bus.time_out), 16'(mk(0, 1)));

    // 6: hold
    load(mk(0, 10));
    bus.hold = 1'b1;
    ticks = 0;
    repeat (50) begin
      step();
      ticks += int'(bus.min_tick);
    end
`ifdef TIMER_HOLD_EN
    chk("t6_frozen", 16'(bus.time_out), 16'(mk(0, 10)));
    chk("t6_no_tick", 16'(ticks), 16'(0));
    load(mk(0, 20));
    chk("t6_load_in_hold", 16'(bus.time_out), 16'(mk(0, 20)));
`else
    chk("t6_hold_ignored", 16'(bus.time_out), 16'(mk(0, 35)));
    chk("t6_ticks", 16'(ticks), 16'(25));
`endif
    bus.hold = 1'b0;

    // random traffic
    for (int n = 0; n < 800; n++) begin
      bus.load_en = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 1)
        bus.load_time = mk($urandom_range(0, HM - 1), $urandom_range(0, MM - 1));
      else
        bus.load_time = 11'($urandom);
      bus.hold = ($urandom_range(0, 7) == 0);
      bus.alarm_clr = 4'($urandom) & {4{($urandom_range(0, 3) == 0)}};
      if ($urandom_range(0, 7) == 0) bus.alarm_en = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, NCH - 1);
        if ($urandom_range(0, 3) == 0)
          bus.reset_time[11*k +: 11] = 11'($urandom);
        else
          bus.reset_time[11*k +: 11] = mk(((m_tot + $urandom_range(0, 3)) % DAY) / MM,
                                          ((m_tot + $urandom_range(0, 3)) % DAY) % MM);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
